// File: rtl/trap_ctrl.sv
// Machine-mode interrupt/trap sequencer: owns mtime/mtimecmp, synchronises ext_irq, and drives trap/redirect strobes.
// Optional macro SW_IRQ_EN adds the msip software-interrupt source (MEI > MSI > MTI).
module trap_ctrl #(
  parameter logic [31:0] MTVEC_ADDR = 32'h0000_0100,
  parameter int unsigned TIMER_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ext_irq,
`ifdef SW_IRQ_EN
  input  logic        msip,
`endif
  input  logic        mstatus_mie,
  input  logic [31:0] mie,
  input  logic [31:0] epc,
  input  logic [31:0] pc_ex,
  input  logic        inst_valid,
  input  logic        is_mret,
  input  logic        cmp_wr,
  input  logic [31:0] cmp_wdata,
  output logic        trap,
  output logic [31:0] trap_pc,
  output logic [31:0] mcause,
  output logic [31:0] mip,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        mie_clr,
  output logic        mie_set,
  output logic [31:0] mtime
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TRAP    = 2'd1,
    ST_HANDLER = 2'd2,
    ST_RETURN  = 2'd3
  } state_e;

  localparam logic [15:0] DIV_LAST  = 16'(TIMER_DIV - 1);
  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
  localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

  state_e      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [31:0] mtime_q, mtime_d;
  logic [31:0] mtimecmp_q, mtimecmp_d;
  logic        sync1_q, sync2_q;
  logic        trap_q, trap_d;
  logic        redirect_q, redirect_d;
  logic        mie_clr_q, mie_clr_d;
  logic        mie_set_q, mie_set_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic        meip, mtip, msip_p;
  logic        mei_en, msi_en, mti_en;
  logic        take;
  logic [31:0] cause;
  logic        unused_mie;

`ifdef SW_IRQ_EN
  assign msip_p = msip;
`else
  assign msip_p = 1'b0;
`endif

  assign unused_mie = ^{mie[31:12], mie[10:8], mie[6:0]};

  assign meip   = sync2_q;
  assign mtip   = (mtime_q >= mtimecmp_q);
  assign mei_en = meip & mie[11];
  assign msi_en = msip_p & mie[3];
  assign mti_en = mtip & mie[7];

  // Boundary check: mret never serves as an interrupt boundary.
  assign take = (state_q == ST_IDLE) & inst_valid & ~is_mret & mstatus_mie
              & (mei_en | msi_en | mti_en);

  always_comb begin
    cause = CAUSE_MTI;
    if (mei_en) begin
      cause = CAUSE_MEI;
    end else if (msi_en) begin
      cause = CAUSE_MSI;
    end
  end

  always_comb begin
    presc_d    = presc_q + 16'd1;
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    if (presc_q == DIV_LAST) begin
      presc_d = 16'd0;
      mtime_d = mtime_q + 32'd1;
    end
    if (cmp_wr) begin
      mtimecmp_d = cmp_wdata;
    end
  end

  // Strobes are computed one cycle ahead so they coincide with TRAP/RETURN.
  always_comb begin
    state_d       = state_q;
    trap_d        = 1'b0;
    redirect_d    = 1'b0;
    mie_clr_d     = 1'b0;
    mie_set_d     = 1'b0;
    trap_pc_d     = trap_pc_q;
    mcause_d      = mcause_q;
    redirect_pc_d = redirect_pc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (take) begin
          state_d       = ST_TRAP;
          trap_d        = 1'b1;
          redirect_d    = 1'b1;
          mie_clr_d     = 1'b1;
          trap_pc_d     = pc_ex;
          mcause_d      = cause;
          redirect_pc_d = MTVEC_ADDR;
        end
      end
      ST_TRAP: begin
        state_d = ST_HANDLER;
      end
      ST_HANDLER: begin
        if (inst_valid && is_mret) begin
          state_d       = ST_RETURN;
          redirect_d    = 1'b1;
          mie_set_d     = 1'b1;
          redirect_pc_d = epc;
        end
      end
      ST_RETURN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      presc_q       <= 16'd0;
      mtime_q       <= 32'd0;
      mtimecmp_q    <= 32'hFFFF_FFFF;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      trap_q        <= 1'b0;
      redirect_q    <= 1'b0;
      mie_clr_q     <= 1'b0;
      mie_set_q     <= 1'b0;
      trap_pc_q     <= 32'd0;
      mcause_q      <= 32'd0;
      redirect_pc_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      mtime_q       <= mtime_d;
      mtimecmp_q    <= mtimecmp_d;
      sync1_q       <= ext_irq;
      sync2_q       <= sync1_q;
      trap_q        <= trap_d;
      redirect_q    <= redirect_d;
      mie_clr_q     <= mie_clr_d;
      mie_set_q     <= mie_set_d;
      trap_pc_q     <= trap_pc_d;
      mcause_q      <= mcause_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign trap        = trap_q;
  assign redirect    = redirect_q;
  assign mie_clr     = mie_clr_q;
  assign mie_set     = mie_set_q;
  assign trap_pc     = trap_pc_q;
  assign mcause      = mcause_q;
  assign redirect_pc = redirect_pc_q;
  assign mtime       = mtime_q;
  assign mip         = {20'd0, meip, 3'd0, mtip, 3'd0, msip_p, 3'd0};

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios then random stimulus, all checked every cycle against a trap/return phase model.
module tb_trap_ctrl;
  localparam logic [31:0] MTVEC = 32'h0000_0100;
  localparam int TDIV = 3;
  localparam int M_IDLE = 0, M_TRAP = 1, M_HANDLER = 2, M_RETURN = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ext_irq, mstatus_mie, inst_valid, is_mret, cmp_wr;
  logic [31:0] mie, epc, pc_ex, cmp_wdata;
  logic        trap, redirect, mie_clr, mie_set;
  logic [31:0] trap_pc, mcause, mip, redirect_pc, mtime;

  trap_ctrl #(.MTVEC_ADDR(MTVEC), .TIMER_DIV(TDIV)) dut (
    .clk(clk), .rst(rst), .ext_irq(ext_irq),
`ifdef SW_IRQ_EN
    .msip(1'b0),
`endif
    .mstatus_mie(mstatus_mie), .mie(mie), .epc(epc), .pc_ex(pc_ex),
    .inst_valid(inst_valid), .is_mret(is_mret), .cmp_wr(cmp_wr), .cmp_wdata(cmp_wdata),
    .trap(trap), .trap_pc(trap_pc), .mcause(mcause), .mip(mip),
    .redirect(redirect), .redirect_pc(redirect_pc), .mie_clr(mie_clr), .mie_set(mie_set),
    .mtime(mtime)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Reference: timer as a cycle count, synchroniser as a 2-deep history of ext_irq, sequencer as a phase.
  int          m_mode;
  int          m_tick;
  logic [31:0] m_mtime, m_cmp, m_mcause, m_trap_pc, m_redir_pc;
  bit          ext_hist[2];

  task automatic model_update();
    bit meip, mtip, mei_en, take;
    if (!rst) begin
      m_mode = M_IDLE; m_tick = 0; m_mtime = 0; m_cmp = 32'hFFFF_FFFF;
      m_mcause = 0; m_trap_pc = 0; m_redir_pc = 0;
      ext_hist[0] = 0; ext_hist[1] = 0;
      return;
    end
    meip   = ext_hist[1];
    mtip   = (m_mtime >= m_cmp);
    mei_en = meip && mie[11];
    take   = (m_mode == M_IDLE) && inst_valid && !is_mret && mstatus_mie && (mei_en || (mtip && mie[7]));
    case (m_mode)
      M_IDLE: if (take) begin
        m_mode     = M_TRAP;
        m_trap_pc  = pc_ex;
        m_mcause   = mei_en ? 32'h8000_000B : 32'h8000_0007;
        m_redir_pc = MTVEC;
        $display("trap   pc=%h cause=%h t=%0t", pc_ex, m_mcause, $time);
      end
      M_TRAP: m_mode = M_HANDLER;
      M_HANDLER: if (inst_valid && is_mret) begin
        m_mode     = M_RETURN;
        m_redir_pc = epc;
        $display("mret   target=%h t=%0t", epc, $time);
      end
      default: m_mode = M_IDLE;
    endcase
    if (m_tick == TDIV - 1) begin m_tick = 0; m_mtime = m_mtime + 1; end
    else m_tick++;
    if (cmp_wr) m_cmp = cmp_wdata;
    ext_hist[1] = ext_hist[0];
    ext_hist[0] = ext_irq;
  endtask

  task automatic check_outputs();
    logic [31:0] exp_mip;
    exp_mip = (ext_hist[1] ? 32'h800 : 32'h0) | ((m_mtime >= m_cmp) ? 32'h80 : 32'h0);
    check_val("trap",     32'(trap),     32'(m_mode == M_TRAP));
    check_val("mie_clr",  32'(mie_clr),  32'(m_mode == M_TRAP));
    check_val("redirect", 32'(redirect), 32'(m_mode == M_TRAP || m_mode == M_RETURN));
    check_val("mie_set",  32'(mie_set),  32'(m_mode == M_RETURN));
    check_val("mip",      mip,     exp_mip);
    check_val("mtime",    mtime,   m_mtime);
    check_val("mcause",   mcause,  m_mcause);
    check_val("trap_pc",  trap_pc, m_trap_pc);
    if (m_mode == M_TRAP || m_mode == M_RETURN) check_val("redirect_pc", redirect_pc, m_redir_pc);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_outputs();
  endtask

  task automatic set_quiet();
    ext_irq = 0; mstatus_mie = 0; mie = 0; epc = 0; pc_ex = 0;
    inst_valid = 0; is_mret = 0; cmp_wr = 0; cmp_wdata = 0;
  endtask

  task automatic do_reset();
    set_quiet();
    rst = 0;
    step(); step();
    rst = 1;
  endtask

  initial begin
    int lat;
    bit seen;
    rst = 0;
    set_quiet();
    #1;
    do_reset();
    check_val("reset_mip", mip, 32'h0);

    // Timer interrupt entry, masking in handler, return and re-entry.
    cmp_wr = 1; cmp_wdata = 32'd20; step(); cmp_wr = 0;
    mie = 32'h80; mstatus_mie = 1; inst_valid = 1; pc_ex = 32'h40;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      if (m_mode == M_TRAP) seen = 1;
    end
    check_val("timer_trap_seen", 32'(seen), 32'd1);
    check_val("timer_trap_pc", trap_pc, 32'h40);
    check_val("timer_mcause", mcause, 32'h8000_0007);
    check_val("timer_redirect_pc", redirect_pc, 32'h100);
    mstatus_mie = 0;
    for (int i = 0; i < 6; i++) step();
    mstatus_mie = 1;
    for (int i = 0; i < 4; i++) step();
    is_mret = 1; epc = 32'h40; step(); is_mret = 0;
    check_val("ret_redirect_pc", redirect_pc, 32'h40);
    step(); step();
    check_val("reentry_trap", 32'(trap), 32'd1);
    mstatus_mie = 0; step();
    is_mret = 1; step(); is_mret = 0; step();
    is_mret = 1;
    for (int i = 0; i < 4; i++) step();
    check_val("idle_mret_redirect", 32'(redirect), 32'd0);
    is_mret = 0;

    // External interrupt latency through the synchroniser.
    do_reset();
    mie = 32'h880; mstatus_mie = 1; inst_valid = 1; pc_ex = 32'h80;
    ext_irq = 1;
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      step();
      if (trap) lat = k;
    end
    check_val("ext_latency", 32'(lat), 32'd3);
    check_val("ext_mcause", mcause, 32'h8000_000B);

    // Both pending while masked, then priority on unmask, then reset during TRAP.
    do_reset();
    mie = 32'h880; cmp_wr = 1; cmp_wdata = 32'd0; ext_irq = 1; inst_valid = 1; pc_ex = 32'h44;
    step(); cmp_wr = 0;
    for (int i = 0; i < 50; i++) step();
    check_val("masked_mip", mip, 32'h880);
    mstatus_mie = 1;
    step();
    check_val("prio_trap", 32'(trap), 32'd1);
    check_val("prio_mcause", mcause, 32'h8000_000B);
    rst = 0; step(); rst = 1;
    check_val("rst_trap", 32'(trap), 32'd0);
    check_val("rst_mtime", mtime, 32'd0);
    check_val("rst_mip", mip, 32'd0);

    // Randomised traffic.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 299) != 0);
      ext_irq     = ext_irq ^ ($urandom_range(0, 19) == 0);
      mstatus_mie = ($urandom_range(0, 3) != 0);
      mie         = $urandom();
      inst_valid  = ($urandom_range(0, 3) != 0);
      is_mret     = ($urandom_range(0, 7) == 0);
      pc_ex       = $urandom() & 32'hFFFF_FFFC;
      epc         = $urandom() & 32'hFFFF_FFFC;
      cmp_wr      = ($urandom_range(0, 31) == 0);
      case ($urandom_range(0, 5))
        0:       cmp_wdata = 32'hFFFF_FFFF;
        1:       cmp_wdata = 32'd0;
        default: cmp_wdata = m_mtime + 32'($urandom_range(0, 40)) - 32'd10;
      endcase
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
